// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: default widths,
// sequencer state encoding and the hard-wired zero-register address.
package gpr_pkg;

    localparam int unsigned GPR_DATA_W    = 32;
    localparam int unsigned GPR_ADDR_W    = 5;
    localparam int unsigned GPR_ZERO_ADDR = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } gpr_state_e;

    // A write to the zero register is discarded when that register is hard-wired.
    function automatic logic gpr_wr_allowed(input logic we,
                                            input logic is_zero_addr,
                                            input logic zero_reg);
        return we && !(zero_reg && is_zero_addr);
    endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: entry mux with zero-register and
// write-first bypass priority; returns zero while the array is clearing.
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter  int unsigned DATA_W   = GPR_DATA_W,
    parameter  int unsigned ADDR_W   = GPR_ADDR_W,
    parameter  int unsigned BYPASS   = 1,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned DEPTH    = 2 ** ADDR_W
) (
    input  logic                         run_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_i,
    input  logic                         wr_ok_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic [DATA_W-1:0]            rd_data_o
);

    logic is_zero;
    logic hit_wr;

    assign is_zero = (ZERO_REG != 0) && (rd_addr_i == ADDR_W'(GPR_ZERO_ADDR));
    assign hit_wr  = (BYPASS != 0) && wr_ok_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = '0;
        if (!run_i || is_zero) begin
            rd_data_o = '0;
        end else if (hit_wr) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = entry_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/gpr_file.sv
// Parametrised register file with NUM_RD read ports, one write port and a
// self-clearing sequencer that zeroes every entry after reset.
//
//   state    | meaning
//   ST_CLEAR | one entry zeroed per cycle, writes dropped, reads return 0
//   ST_RUN   | array usable, ready high, writes accepted
module gpr_file
    import gpr_pkg::*;
#(
    parameter  int unsigned DATA_W   = GPR_DATA_W,
    parameter  int unsigned ADDR_W   = GPR_ADDR_W,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned BYPASS   = 1,
    parameter  int unsigned ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        num_write,
    input  logic [DATA_W-1:0]        data_write,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     ready
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    gpr_state_e                   state_q, state_d;
    logic [ADDR_W-1:0]            clr_cnt_q, clr_cnt_d;
    logic                         ready_q, ready_d;
    logic [DEPTH-1:0][DATA_W-1:0] entry_q;

    logic              run;
    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign run   = (state_q == ST_RUN);
    assign wr_ok = gpr_wr_allowed(reg_write,
                                  num_write == ADDR_W'(GPR_ZERO_ADDR),
                                  ZERO_REG != 0);

    // The clear sequencer owns the array write port until the last entry is zeroed.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_addr  = num_write;
        mem_wdata = data_write;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end else begin
            mem_we = wr_ok;
        end
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            if (mem_we) begin
                entry_q[mem_addr] <= mem_wdata;
            end
        end
    end

    assign ready = ready_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        gpr_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .run_i    (run),
            .rd_addr_i(rd_addr[g*ADDR_W +: ADDR_W]),
            .entry_i  (entry_q),
            .wr_ok_i  (wr_ok),
            .wr_addr_i(num_write),
            .wr_data_i(data_write),
            .rd_data_o(rd_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: a default instance and a 3-port/8-entry/16-bit instance
// without bypass or zero register, both checked against array models.
module tb_gpr_file;

    logic        clock;
    logic        reset;

    logic        rw0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [9:0]  ra0;
    logic [63:0] rd0;
    logic        rdy0;

    logic        rw1;
    logic [2:0]  wa1;
    logic [15:0] wd1;
    logic [8:0]  ra1;
    logic [47:0] rd1;
    logic        rdy1;

    gpr_file u_dut (
        .clock     (clock),
        .reset     (reset),
        .reg_write (rw0),
        .num_write (wa0),
        .data_write(wd0),
        .rd_addr   (ra0),
        .rd_data   (rd0),
        .ready     (rdy0)
    );

    gpr_file #(
        .DATA_W  (16),
        .ADDR_W  (3),
        .NUM_RD  (3),
        .BYPASS  (0),
        .ZERO_REG(0)
    ) u_alt (
        .clock     (clock),
        .reset     (reset),
        .reg_write (rw1),
        .num_write (wa1),
        .data_write(wd1),
        .rd_addr   (ra1),
        .rd_data   (rd1),
        .ready     (rdy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference state: array contents and clear cycles still to run.
    logic [31:0] mem0 [32];
    logic [15:0] mem1 [8];
    int          clr0;
    int          clr1;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp0(input int p);
        logic [4:0] a;
        a = ra0[p*5 +: 5];
        if (clr0 != 0) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (rw0 && wa0 == a) return wd0;
        return mem0[a];
    endfunction

    function automatic logic [15:0] exp1(input int p);
        logic [2:0] a;
        a = ra1[p*3 +: 3];
        if (clr1 != 0) return 16'h0;
        return mem1[a];
    endfunction

    task automatic model_edge();
        if (reset) begin
            clr0 = 32;
            clr1 = 8;
            for (int i = 0; i < 32; i++) mem0[i] = '0;
            for (int i = 0; i < 8; i++) mem1[i] = '0;
        end else begin
            if (clr0 > 0) clr0--;
            else if (rw0 && wa0 != 5'd0) mem0[wa0] = wd0;
            if (clr1 > 0) clr1--;
            else if (rw1) mem1[wa1] = wd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/rdy0"}, 32'(rdy0), 32'(clr0 == 0));
        for (int p = 0; p < 2; p++) chk({tag, "/rd0"}, rd0[p*32 +: 32], exp0(p));
        chk({tag, "/rdy1"}, 32'(rdy1), 32'(clr1 == 0));
        for (int p = 0; p < 3; p++) chk({tag, "/rd1"}, 32'(rd1[p*16 +: 16]), 32'(exp1(p)));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        step();
    endtask

    task automatic measure(input string tag, input int e0, input int e1);
        int lo0;
        int lo1;
        lo0 = 0;
        lo1 = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            check_all(tag);
            if (rdy0 && rdy1) break;
            if (!rdy0) lo0++;
            if (!rdy1) lo1++;
            step();
        end
        chk({tag, "/lo_cycles0"}, 32'(lo0), 32'(e0));
        chk({tag, "/lo_cycles1"}, 32'(lo1), 32'(e1));
    endtask

    task automatic idle();
        rw0 = 1'b0;
        rw1 = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        clr0 = 32;
        clr1 = 8;
        reset = 1'b1;
        rw0 = 1'b0; wa0 = '0; wd0 = '0; ra0 = '0;
        rw1 = 1'b0; wa1 = '0; wd1 = '0; ra1 = '0;
        for (int i = 0; i < 32; i++) mem0[i] = '0;
        for (int i = 0; i < 8; i++) mem1[i] = '0;

        step();
        reset = 1'b0;
        measure("init", 32, 8);

        // fill, then one-cycle reset must zero everything
        for (int a = 0; a < 32; a++) begin
            rw0 = 1'b1; wa0 = 5'(a); wd0 = 32'hA5A5A5A5;
            rw1 = 1'b1; wa1 = 3'(a); wd1 = 16'hA5A5;
            ra0 = 10'($urandom); ra1 = 9'($urandom);
            cycle("fill");
        end
        idle();
        #1;
        ra0 = {5'd9, 5'd17};
        ra1 = {3'd1, 3'd2, 3'd3};
        #1;
        chk("fill_rd17", rd0[31:0], 32'hA5A5A5A5);
        chk("fill_alt", 32'(rd1[15:0]), 32'h0000A5A5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        measure("rst_clear", 32, 8);
        for (int a = 0; a < 32; a++) begin
            ra0 = {5'(a ^ 1), 5'(a)};
            ra1 = {3'(a), 3'(a + 1), 3'(a + 2)};
            #1;
            chk("cleared", rd0[31:0], 32'h0);
            cycle("cleared");
        end

        // zero register
        rw0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; ra0 = {5'd4, 5'd0};
        rw1 = 1'b1; wa1 = 3'd0; wd1 = 16'hBEEF;     ra1 = {3'd6, 3'd5, 3'd0};
        #1;
        chk("zero_pre", rd0[31:0], 32'h0);
        check_all("zero_pre");
        step();
        idle();
        #1;
        chk("zero_post", rd0[31:0], 32'h0);
        chk("zero_alt", 32'(rd1[15:0]), 32'h0000BEEF);
        check_all("zero_post");
        step();

        // bypass on the default instance, read-old on the alternate one
        rw0 = 1'b1; wa0 = 5'd8; wd0 = 32'h12345678; ra0 = {5'd8, 5'd1};
        rw1 = 1'b1; wa1 = 3'd5; wd1 = 16'h1234;     ra1 = {3'd0, 3'd5, 3'd1};
        #1;
        chk("byp_same", rd0[63:32], 32'h12345678);
        chk("nobyp_old", 32'(rd1[31:16]), 32'h0);
        check_all("byp_pre");
        step();
        idle();
        #1;
        chk("byp_after", rd0[63:32], 32'h12345678);
        chk("nobyp_new", 32'(rd1[31:16]), 32'h00001234);
        check_all("byp_post");
        step();

        // write presented during clear is dropped
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle("clr_wr");
        rw0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55; ra0 = {5'd3, 5'd3};
        rw1 = 1'b1; wa1 = 3'd3; wd1 = 16'h55; ra1 = {3'd3, 3'd3, 3'd3};
        cycle("clr_wr");
        idle();
        measure("clr_wr", 26, 2);
        #1;
        chk("clr_wr_drop0", rd0[31:0], 32'h0);
        chk("clr_wr_drop1", 32'(rd1[15:0]), 32'h0);
        step();

        // reset mid-clear restarts the full sequence
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle("mid_clr");
        reset = 1'b1;
        step();
        reset = 1'b0;
        measure("mid_clr", 32, 8);

        // all three ports of the alternate instance on one entry
        rw1 = 1'b1; wa1 = 3'd7; wd1 = 16'h00FF;
        cycle("r7_wr");
        idle();
        ra1 = {3'd7, 3'd7, 3'd7};
        #1;
        for (int p = 0; p < 3; p++) chk("r7_port", 32'(rd1[p*16 +: 16]), 32'h000000FF);
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            rw0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom; ra0 = 10'($urandom);
            rw1 = 1'($urandom); wa1 = 3'($urandom); wd1 = 16'($urandom); ra1 = 9'($urandom);
            if ($urandom_range(0, 3) == 0) ra0[4:0] = wa0;
            if ($urandom_range(0, 3) == 0) ra0[9:5] = wa0;
            if ($urandom_range(0, 3) == 0) ra1[2:0] = wa1;
            cycle("rand");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
